// File: rtl/spm_pkg.sv
// Shared types and sizing helpers for the spm operand sequencer.
package spm_pkg;

  typedef enum logic [2:0] {IDLE, CLR, RUN, DRAIN, DONE} spm_seq_state_t;

  localparam int SPM_W_DEFAULT = 32;

  // Stream counter must reach 2*W+P_LAT-1 without wrapping.
  function automatic int spm_cnt_w(input int w, input int p_lat);
    return $clog2(2 * w + p_lat + 1);
  endfunction

endpackage

// File: rtl/spm_operand_sequencer_if.sv
// Operand-in / product-out valid/ready bundle of the spm operand sequencer.
interface spm_operand_sequencer_if import spm_pkg::*; #(
  parameter int W = SPM_W_DEFAULT
);
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_x;
  logic [W-1:0]   in_y;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_p;

  modport master (
    output in_valid, in_x, in_y, out_ready,
    input  in_ready, out_valid, out_p
  );

  modport slave (
    input  in_valid, in_x, in_y, out_ready,
    output in_ready, out_valid, out_p
  );
endinterface

// File: rtl/spm_ser_shift.sv
// W-bit parallel-load right shifter; the vacated MSB takes the fill bit, LSB is the serial output.
module spm_ser_shift import spm_pkg::*; #(
  parameter int W = SPM_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] load_val,
  input  logic         fill,
  output logic         q_lsb
);
  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_val;
    end else if (shift) begin
      q_d = {fill, q_q[W-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_lsb = q_q[0];
endmodule

// File: rtl/spm_operand_sequencer.sv
// Feeds x in parallel and y serially (LSB first, 2*W bits) to an spm core and collects the product.
// Define SPM_SEQ_SIGN_EXT_EN to treat y as signed (extension bit = y MSB); otherwise y is zero-extended.
module spm_operand_sequencer import spm_pkg::*; #(
  parameter int W     = SPM_W_DEFAULT,
  parameter int P_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  spm_operand_sequencer_if.slave  bus,
  output logic                    spm_rst_o,
  output logic [W-1:0]            x_o,
  output logic                    y_o,
  input  logic                    p_i
);
  localparam int PW = 2 * W;
  localparam int CW = spm_cnt_w(W, P_LAT);
  localparam logic [CW-1:0] RUN_LAST   = CW'(PW - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(PW + P_LAT - 1);
  localparam logic [CW-1:0] CAP_FIRST  = CW'(P_LAT);

  spm_seq_state_t state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   x_q, x_d;
  logic           ext_q, ext_d;
  logic           in_ready_q, in_ready_d;
  logic           spm_rst_q, spm_rst_d;
  logic           y_q, y_d;
  logic           out_valid_q, out_valid_d;
  logic [PW-1:0]  out_p_q, out_p_d;
  logic           ysh_load, ysh_shift, ysh_lsb;
  logic           accept;
  logic           ext_in;

`ifdef SPM_SEQ_SIGN_EXT_EN
  assign ext_in = bus.in_y[W-1];
`else
  assign ext_in = 1'b0;
`endif

  assign accept = (state_q == IDLE) && in_ready_q && bus.in_valid;

  spm_ser_shift #(.W(W)) u_ysh (
    .clk      (clk),
    .rst      (rst),
    .load     (ysh_load),
    .shift    (ysh_shift),
    .load_val (bus.in_y),
    .fill     (ext_q),
    .q_lsb    (ysh_lsb)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    ext_d    = ext_q;
    out_p_d  = out_p_q;
    ysh_load = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          x_d      = bus.in_x;
          ext_d    = ext_in;
          cnt_d    = '0;
          ysh_load = 1'b1;
          state_d  = CLR;
        end
      end
      CLR: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == RUN_LAST) state_d = DRAIN;
      end
      DRAIN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == DRAIN_LAST) state_d = DONE;
      end
      DONE: begin
        if (out_valid_q && bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Product bit k arrives P_LAT cycles after y bit k; shift it in from the MSB end.
    if ((state_q == RUN || state_q == DRAIN) && cnt_q >= CAP_FIRST) begin
      out_p_d = {p_i, out_p_q[PW-1:1]};
    end

    // Outputs are registered, so they are decoded from the state being entered.
    ysh_shift   = (state_d == RUN);
    in_ready_d  = (state_d == IDLE);
    spm_rst_d   = (state_d == CLR);
    out_valid_d = (state_d == DONE);
    if (state_d == RUN) begin
      y_d = ysh_lsb;
    end else if (state_d == DRAIN) begin
      y_d = ext_q;
    end else begin
      y_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      x_q         <= '0;
      ext_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      spm_rst_q   <= 1'b1;
      y_q         <= 1'b0;
      out_valid_q <= 1'b0;
      out_p_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      ext_q       <= ext_d;
      in_ready_q  <= in_ready_d;
      spm_rst_q   <= spm_rst_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
      out_p_q     <= out_p_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_p     = out_p_q;
  assign spm_rst_o     = spm_rst_q;
  assign x_o           = x_q;
  assign y_o           = y_q;
endmodule

// File: tb/tb_spm_operand_sequencer.sv
// Scoreboard bench for spm_operand_sequencer with a behavioural serial-parallel multiplier core.
module tb_spm_operand_sequencer;
  localparam int W     = 32;
  localparam int P_LAT = 1;
  localparam int PW    = 2 * W;
  localparam int LAT   = 1 + 2 * W + P_LAT;
  localparam int BOUND = 1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spm_operand_sequencer_if #(.W(W)) bus();
  logic          spm_rst_o, y_o, p_i;
  logic [W-1:0]  x_o;

  spm_operand_sequencer #(.W(W), .P_LAT(P_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .spm_rst_o (spm_rst_o),
    .x_o       (x_o),
    .y_o       (y_o),
    .p_i       (p_i)
  );

  int     n_checks = 0;
  int     n_fail   = 0;
  longint cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got no event expected event within bound", name);
  endtask

  // Reference: low 2W bits of signed x times extended y.
  function automatic logic [63:0] ref_prod(logic [W-1:0] x, logic [W-1:0] y);
    logic [63:0] xe, ye;
    xe = {{W{x[W-1]}}, x};
`ifdef SPM_SEQ_SIGN_EXT_EN
    ye = {{W{y[W-1]}}, y};
`else
    ye = {{W{1'b0}}, y};
`endif
    return xe * ye;
  endfunction

  // Behavioural spm core: partial sum fixes bit k once y bit k has been added in.
  logic [PW-1:0] acc, acc_nxt;
  int            k;
  logic          p_pipe [P_LAT];
  always @(posedge clk) begin
    if (spm_rst_o) begin
      acc <= '0;
      k   <= 0;
      for (int i = 0; i < P_LAT; i++) p_pipe[i] <= 1'b0;
    end else begin
      acc_nxt = acc;
      if (k < PW && y_o) acc_nxt = acc + ({{W{x_o[W-1]}}, x_o} << k);
      acc <= acc_nxt;
      p_pipe[0] <= (k < PW) ? acc_nxt[k] : 1'b0;
      for (int i = 1; i < P_LAT; i++) p_pipe[i] <= p_pipe[i-1];
      if (k < PW + 8) k <= k + 1;
    end
  end
  assign p_i = p_pipe[P_LAT-1];

  typedef struct {
    logic [63:0]  p;
    longint       acc_cyc;
    logic [W-1:0] x;
    logic [W-1:0] y;
  } exp_t;
  exp_t sb[$];

  logic        prev_ov = 1'b0;
  logic        prev_hs = 1'b0;
  logic [63:0] prev_p  = '0;
  logic [63:0] last_p  = '0;
  int          rst_chk = 0;
  int          n_done  = 0;
  longint      out_hs_edge = 0;

  // Monitor: records accepts into the scoreboard and checks every presented product.
  always @(negedge clk) begin
    exp_t e;
    logic hs;
    if (rst) begin
      sb.delete();
      rst_chk = 0;
      prev_ov = 1'b0;
      prev_hs = 1'b0;
    end else begin
      if (rst_chk == 2) begin
        check("spm_rst_hi", {63'd0, spm_rst_o}, 64'd1);
        rst_chk = 1;
      end else if (rst_chk == 1) begin
        check("spm_rst_lo", {63'd0, spm_rst_o}, 64'd0);
        rst_chk = 0;
      end
      if (prev_ov && !prev_hs) begin
        check("hold_valid", {63'd0, bus.out_valid}, 64'd1);
        check("hold_p", bus.out_p, prev_p);
      end
      if (bus.out_valid) check("busy_in_ready", {63'd0, bus.in_ready}, 64'd0);
      if (bus.out_valid && !prev_ov && sb.size() != 0)
        check("latency", 64'(cyc - sb[0].acc_cyc), 64'(LAT));
      hs = bus.out_valid && bus.out_ready;
      if (hs) begin
        if (sb.size() == 0) begin
          fail("unexpected_out");
        end else begin
          e = sb.pop_front();
          check("product", bus.out_p, e.p);
          $display("op %0d: x=%h y=%h p=%h exp=%h", n_done, e.x, e.y, bus.out_p, e.p);
        end
        last_p      = bus.out_p;
        out_hs_edge = cyc + 1;
        n_done++;
      end
      prev_ov = bus.out_valid;
      prev_p  = bus.out_p;
      prev_hs = hs;
      if (bus.in_valid && bus.in_ready) begin
        e.p = ref_prod(bus.in_x, bus.in_y);
        e.acc_cyc = cyc + 1;
        e.x = bus.in_x;
        e.y = bus.in_y;
        sb.push_back(e);
        rst_chk = 2;
      end
    end
  end

  logic rand_ready = 1'b0;
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
  end

  task automatic check_reset_state();
    check("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    check("rst_spm_rst", {63'd0, spm_rst_o}, 64'd1);
    check("rst_x_o", {32'd0, x_o}, 64'd0);
    check("rst_y_o", {63'd0, y_o}, 64'd0);
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_out_p", bus.out_p, 64'd0);
  endtask

  task automatic send(logic [W-1:0] x, logic [W-1:0] y, bit hold);
    int t;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.in_x = x;
    bus.in_y = y;
    t = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      t++;
      if (t > BOUND) begin
        fail("accept_timeout");
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!hold) bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(int target);
    int t;
    t = 0;
    while (n_done < target) begin
      @(negedge clk);
      t++;
      if (t > BOUND) begin
        fail("done_timeout");
        break;
      end
    end
  endtask

  initial begin
    int n0, t;
    logic [W-1:0] rx, ry;
    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.in_y      = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_state();
    @(posedge clk);
    #1 rst = 1'b0;

    send(32'd3, 32'd5, 0);
    wait_done(1);
    check("t1_p", last_p, 64'd15);

    send(32'hFFFF_FFFE, 32'd7, 0);
    wait_done(2);
    check("t2_p", last_p, 64'hFFFF_FFFF_FFFF_FFF2);

    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    wait_done(3);
`ifdef SPM_SEQ_SIGN_EXT_EN
    check("t3_p", last_p, 64'd1);
`else
    check("t3_p", last_p, 64'hFFFF_FFFF_0000_0001);
`endif

    // Backpressure: hold the product for 10 cycles in DONE.
    bus.out_ready = 1'b0;
    send(32'h1234_5678, 32'h0BAD_F00D, 0);
    t = 0;
    while (!bus.out_valid && t <= BOUND) begin
      @(negedge clk);
      t++;
    end
    if (t > BOUND) fail("t4_valid_timeout");
    repeat (10) @(negedge clk);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    wait_done(4);

    // Reset while RUN is at cnt=20: operand is dropped, next op must be clean.
    send(32'h0000_0ABC, 32'h0000_1DEF, 0);
    repeat (21) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_state();
    check("t5_no_done", 64'(n_done), 64'd4);
    @(posedge clk);
    #1 rst = 1'b0;
    send(32'd6, 32'd9, 0);
    wait_done(5);
    check("t5_p", last_p, 64'd54);

    // Back-to-back: second operand waits with in_valid high during op 1.
    n0 = n_done;
    send(32'h8000_0001, 32'h0000_0003, 1);
    bus.in_x = 32'h7FFF_FFFF;
    bus.in_y = 32'h8000_0000;
    t = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      t++;
      if (t > BOUND) begin
        fail("t6_ready_timeout");
        break;
      end
    end
    check("t6_accept_cycle", 64'(cyc), 64'(out_hs_edge));
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    wait_done(n0 + 2);

    // Randomized operands, gaps and consumer backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rx = $urandom;
      ry = $urandom;
      if (i % 4 == 0) ry[W-1] = 1'b1;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      send(rx, ry, 0);
    end
    wait_done(n0 + 2 + 16);
    rand_ready = 1'b0;
    #1 bus.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

  initial begin
    #900000;
    fail("global_timeout");
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end
endmodule
